wb_port_arbiter: RTL

Shares the single register-file write port between the P5 write-back stream and the multi-cycle unit (MDU) result channel. P5 always has priority. An MDU result waits in a one-entry holding register until P5 leaves the port idle. If P5 keeps the port busy for `STARVE_LIMIT` cycles, the arbiter asserts a one-cycle stall so the pipeline inserts a bubble and the held result gets written. The block sits between the P4/P5 pipeline register, the MDU and the register file, and it exports the pending destination to hazard detection.

---
 rtl/wb_port_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Shares the register-file write port between P5 write-back and a
//            one-entry MDU holding register, with a forced-write anti-starve.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_p5_wr_en,
    input  logic [4:0]      i_p5_rd,
    input  logic [XLEN-1:0] i_p5_data,
    input  logic            i_mdu_valid,
    input  logic [4:0]      i_mdu_rd,
    input  logic [XLEN-1:0] i_mdu_data,
    output logic            o_mdu_ready,
    output logic            o_rf_wr_en,
    output logic [4:0]      o_rf_rd,
    output logic [XLEN-1:0] o_rf_data,
    output logic            o_stall,
    output logic            o_pend_valid,
    output logic [4:0]      o_pend_rd
);

    localparam int                   c_CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0]   c_LIMIT   = c_CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] c_ST_EMPTY = 2'd0;
    localparam logic [1:0] c_ST_HOLD  = 2'd1;
    localparam logic [1:0] c_ST_FORCE = 2'd2;

    logic [1:0]         r_state;
    logic               r_hold_v;
    logic [4:0]         r_hold_rd;
    logic [XLEN-1:0]    r_hold_data;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stall;

    logic               w_p5_wr;
    logic               w_mdu_xfer;
    logic [c_CNT_W-1:0] w_cnt_inc;

    assign w_p5_wr     = i_p5_wr_en & (i_p5_rd != 5'd0);
    assign o_mdu_ready = ~r_hold_v & i_rst_n;
    assign w_mdu_xfer  = i_mdu_valid & o_mdu_ready;
    assign w_cnt_inc   = r_cnt + 1'b1;

    assign o_stall      = r_stall;
    assign o_pend_valid = r_hold_v;
    assign o_pend_rd    = r_hold_rd;

    // Write-port mux; x0 never reaches the port since hold_rd is never 0.
    always_comb begin
        o_rf_wr_en = 1'b0;
        o_rf_rd    = 5'd0;
        o_rf_data  = '0;
        if (i_rst_n) begin
            case (r_state)
                c_ST_EMPTY: begin
                    o_rf_wr_en = w_p5_wr;
                    o_rf_rd    = i_p5_rd;
                    o_rf_data  = i_p5_data;
                end
                c_ST_HOLD: begin
                    if (w_p5_wr) begin
                        o_rf_wr_en = 1'b1;
                        o_rf_rd    = i_p5_rd;
                        o_rf_data  = i_p5_data;
                    end else begin
                        o_rf_wr_en = 1'b1;
                        o_rf_rd    = r_hold_rd;
                        o_rf_data  = r_hold_data;
                    end
                end
                c_ST_FORCE: begin
                    o_rf_wr_en = 1'b1;
                    o_rf_rd    = r_hold_rd;
                    o_rf_data  = r_hold_data;
                end
                default: begin
                    o_rf_wr_en = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= c_ST_EMPTY;
            r_hold_v    <= 1'b0;
            r_hold_rd   <= 5'd0;
            r_hold_data <= '0;
            r_cnt       <= '0;
            r_stall     <= 1'b0;
        end else begin
            r_stall <= 1'b0;
            case (r_state)
                c_ST_EMPTY: begin
                    // rd==0 transfers are consumed without occupying the hold
                    if (w_mdu_xfer && (i_mdu_rd != 5'd0)) begin
                        r_state     <= c_ST_HOLD;
                        r_hold_v    <= 1'b1;
                        r_hold_rd   <= i_mdu_rd;
                        r_hold_data <= i_mdu_data;
                        r_cnt       <= '0;
                    end
                end
                c_ST_HOLD: begin
                    if (w_p5_wr) begin
                        if (i_p5_rd == r_hold_rd) begin
                            // Younger P5 write supersedes the held result
                            r_state  <= c_ST_EMPTY;
                            r_hold_v <= 1'b0;
                            r_cnt    <= '0;
                        end else if (w_cnt_inc == c_LIMIT) begin
                            r_state <= c_ST_FORCE;
                            r_cnt   <= w_cnt_inc;
                            r_stall <= 1'b1;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_state  <= c_ST_EMPTY;
                        r_hold_v <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                c_ST_FORCE: begin
                    r_state  <= c_ST_EMPTY;
                    r_hold_v <= 1'b0;
                    r_cnt    <= '0;
                end
                default: begin
                    r_state  <= c_ST_EMPTY;
                    r_hold_v <= 1'b0;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
